// File: rtl/pipe_addsub_pkg.sv
// pipe_addsub_pkg: shared defaults and op encoding for the pipelined adder/subtractor
package pipe_addsub_pkg;
  localparam int N_DEF = 32;
  localparam int STAGES_DEF = 4;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
endpackage

// File: rtl/pipe_addsub_if.sv
// pipe_addsub_if: operand/result handshake bundle for pipe_addsub
interface pipe_addsub_if import pipe_addsub_pkg::*; #(parameter int N = N_DEF);
  logic in_valid;
  logic in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] result;
  logic cout;
  logic overflow;
  logic zero;
  logic neg;
  modport master (
    output in_valid, a, b, sub, out_ready,
    input in_ready, out_valid, result, cout, overflow, zero, neg
  );
  modport slave (
    input in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero, neg
  );
endinterface

// File: rtl/pipe_addsub_add_chunk.sv
// add_chunk: W-bit ripple chunk exposing carry-out and carry into the MSB
module add_chunk #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);
  assign {cmsb, sum[W-2:0]} = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{W-1{1'b0}}, cin};
  assign {cout, sum[W-1]} = {1'b0, a[W-1]} + {1'b0, b[W-1]} + {1'b0, cmsb};
endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: STAGES-deep chunked ripple adder/subtractor with valid/ready handshake
module pipe_addsub import pipe_addsub_pkg::*; #(
  parameter int N = N_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input logic clk,
  input logic rst_n,
  pipe_addsub_if.slave io
);
  localparam int W = N / STAGES;
  logic v [STAGES];
  logic [N-1:0] r [STAGES];
  logic c [STAGES];
  logic z [STAGES];
  logic o [STAGES];
  logic [N-W-1:0] ar [STAGES-1];
  logic [N-W-1:0] br [STAGES-1];
  logic [W-1:0] ca [STAGES];
  logic [W-1:0] cb [STAGES];
  logic [W-1:0] s [STAGES];
  logic ci [STAGES];
  logic co [STAGES];
  logic cm [STAGES];
  logic ld [STAGES];
  logic zin [STAGES];
  logic [N-1:0] rin [STAGES];
  logic [N-1:0] bx;
  logic [STAGES-1:0] adv;
  assign bx = io.b ^ {N{io.sub}};
  // a stage advances when some stage below it is empty or the output retires
  always_comb begin
    logic f;
    adv = '0;
    f = io.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = v[k] & f;
      f = f | !v[k];
    end
  end
  assign io.in_ready = !v[0] | adv[0];
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k == 0) begin : g_first
      assign ca[k] = io.a[W-1:0];
      assign cb[k] = bx[W-1:0];
      assign ci[k] = io.sub;
      assign ld[k] = io.in_valid & io.in_ready;
      assign rin[k] = '0;
      assign zin[k] = 1'b1;
    end else begin : g_next
      assign ca[k] = ar[k-1][W-1:0];
      assign cb[k] = br[k-1][W-1:0];
      assign ci[k] = c[k-1];
      assign ld[k] = adv[k-1];
      assign rin[k] = r[k-1];
      assign zin[k] = z[k-1];
    end
    if (k < STAGES - 1) begin : g_op
      logic [N-W-1:0] an;
      logic [N-W-1:0] bn;
      if (k == 0) begin : g_in
        assign an = io.a[N-1:W];
        assign bn = bx[N-1:W];
      end else begin : g_shift
        assign an = ar[k-1] >> W;
        assign bn = br[k-1] >> W;
      end
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          ar[k] <= '0;
          br[k] <= '0;
        end else if (ld[k]) begin
          ar[k] <= an;
          br[k] <= bn;
        end
    end
    add_chunk #(.W(W)) u_add (
      .a(ca[k]), .b(cb[k]), .cin(ci[k]), .sum(s[k]), .cout(co[k]), .cmsb(cm[k])
    );
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v[k] <= 1'b0;
        r[k] <= '0;
        c[k] <= 1'b0;
        z[k] <= 1'b0;
        o[k] <= 1'b0;
      end else begin
        v[k] <= ld[k] | (v[k] & !adv[k]);
        if (ld[k]) begin
          r[k] <= rin[k];
          r[k][k*W +: W] <= s[k];
          c[k] <= co[k];
          z[k] <= zin[k] & ~|s[k];
          o[k] <= cm[k] ^ co[k];
        end
      end
  end
  assign io.out_valid = v[STAGES-1];
  assign io.result = r[STAGES-1];
  assign io.cout = c[STAGES-1];
  assign io.overflow = o[STAGES-1];
  assign io.zero = z[STAGES-1];
  assign io.neg = r[STAGES-1][N-1];
endmodule
